mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 121 ++++++++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns and extends load data, flags misaligned loads,
// and counts instructions retiring out of the WB stage.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_pc_plus4,
  input  logic [31:0] mem_imm,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_read,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_wb_sel,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] wb_in0,
  output logic [31:0] wb_in1,
  output logic [31:0] wb_in2,
  output logic [31:0] wb_in3,
  output logic [1:0]  wb_sel,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_valid,
  output logic        wb_load_misaligned,
  output logic [31:0] retired_count
);

  typedef struct packed {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] in3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        reg_write;
    logic        valid;
    logic        mis;
  } wb_t;

  wb_t         wb_q, wb_d, cap;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  addr;
  logic [31:0] shifted;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        mis;
  logic        ret_adv;

  assign addr    = mem_alu_result[1:0];
  assign shifted = mem_rdata >> {addr, 3'b000};
  assign ld_b    = shifted[7:0];
  assign ld_h    = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    mis     = 1'b0;
    case (mem_funct3)
      3'b000: ld_data = {{24{ld_b[7]}}, ld_b};
      3'b100: ld_data = {24'b0, ld_b};
      3'b001: begin ld_data = {{16{ld_h[15]}}, ld_h}; mis = addr[0]; end
      3'b101: begin ld_data = {16'b0, ld_h};          mis = addr[0]; end
      3'b010: mis = (addr != 2'b00);
      default: ld_data = mem_rdata;
    endcase
    mis = mis & mem_valid & mem_read;
  end

  always_comb begin
    cap.in0       = mem_alu_result;
    cap.in1       = mis ? 32'b0 : ld_data;
    cap.in2       = mem_pc_plus4;
    cap.in3       = mem_imm;
    cap.sel       = mem_wb_sel;
    cap.rd        = mem_rd;
    cap.reg_write = mem_valid & mem_reg_write & (mem_rd != 5'd0) & ~mis;
    cap.valid     = mem_valid;
    cap.mis       = mis;
  end

  // Flush bubbles the control fields but leaves the data fields held.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d.valid     = 1'b0;
      wb_d.reg_write = 1'b0;
      wb_d.mis       = 1'b0;
      wb_d.rd        = 5'd0;
      wb_d.sel       = 2'b00;
    end else if (!stall) begin
      wb_d = cap;
    end
  end

  assign ret_adv   = wb_q.valid & (~stall | flush);
  assign retired_d = retired_q + {31'b0, ret_adv};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  assign wb_in0             = wb_q.in0;
  assign wb_in1             = wb_q.in1;
  assign wb_in2             = wb_q.in2;
  assign wb_in3             = wb_q.in3;
  assign wb_sel             = wb_q.sel;
  assign wb_rd              = wb_q.rd;
  assign wb_reg_write       = wb_q.reg_write;
  assign wb_valid           = wb_q.valid;
  assign wb_load_misaligned = wb_q.mis;
  assign retired_count      = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference model pushes the expected WB state
// each cycle and it is popped and compared one edge later.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_pc_plus4 = '0;
  logic [31:0] mem_imm = '0;
  logic [4:0]  mem_rd = '0;
  logic        mem_reg_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] wb_in0, wb_in1, wb_in2, wb_in3;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_valid, wb_load_misaligned;
  logic [31:0] retired_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] in0, in1, in2, in3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw, v, mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t m = '0;
  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_rdata(mem_rdata), .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_read(mem_read), .mem_funct3(mem_funct3),
    .mem_wb_sel(mem_wb_sel), .stall(stall), .flush(flush), .wb_in0(wb_in0), .wb_in1(wb_in1),
    .wb_in2(wb_in2), .wb_in3(wb_in3), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_valid(wb_valid), .wb_load_misaligned(wb_load_misaligned),
    .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic step();
    exp_t n, e;
    logic mis;
    n = m;
    if (!rst_n) n = '0;
    else begin
      if (flush) begin
        n.v = 0; n.rw = 0; n.mis = 0; n.rd = 0; n.sel = 0;
      end else if (!stall) begin
        mis = mem_valid && mem_read &&
              (((mem_funct3 == 3'b001 || mem_funct3 == 3'b101) && mem_alu_result[0]) ||
               (mem_funct3 == 3'b010 && mem_alu_result[1:0] != 2'b00));
        n.in0 = mem_alu_result;
        n.in1 = mis ? 32'h0 : ref_load(mem_funct3, mem_alu_result[1:0], mem_rdata);
        n.in2 = mem_pc_plus4;
        n.in3 = mem_imm;
        n.sel = mem_wb_sel;
        n.rd  = mem_rd;
        n.v   = mem_valid;
        n.mis = mis;
        n.rw  = mem_valid && mem_reg_write && mem_rd != 0 && !mis;
      end
      if (m.v && (!stall || flush)) n.cnt = m.cnt + 32'd1;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("in0", wb_in0, e.in0);
    chk("in1", wb_in1, e.in1);
    chk("in2", wb_in2, e.in2);
    chk("in3", wb_in3, e.in3);
    chk("sel", {30'b0, wb_sel}, {30'b0, e.sel});
    chk("rd", {27'b0, wb_rd}, {27'b0, e.rd});
    chk("rw", {31'b0, wb_reg_write}, {31'b0, e.rw});
    chk("valid", {31'b0, wb_valid}, {31'b0, e.v});
    chk("mis", {31'b0, wb_load_misaligned}, {31'b0, e.mis});
    chk("cnt", retired_count, e.cnt);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd_w,
                       input logic [4:0] rd, input logic rw, input logic rdq,
                       input logic [2:0] f3, input logic [1:0] sel);
    mem_valid = v; mem_alu_result = alu; mem_rdata = rd_w; mem_rd = rd;
    mem_reg_write = rw; mem_read = rdq; mem_funct3 = f3; mem_wb_sel = sel;
    mem_pc_plus4 = $urandom; mem_imm = $urandom;
  endtask

  task automatic rand_in();
    drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
          1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
  endtask

  logic [31:0] cnt0;

  initial begin
    // reset state
    step(); step();
    chk("rst_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_cnt", retired_count, 32'd0);
    rst_n = 1'b1;

    drive(1, 32'h1003, 32'h80FF_1234, 5'd5, 1, 1, 3'b000, 2'd1); step();
    chk("lb_in1", wb_in1, 32'hFFFF_FF80);
    chk("lb_rw", {31'b0, wb_reg_write}, 32'd1);
    drive(1, 32'h2002, 32'hBEEF_0000, 5'd6, 1, 1, 3'b101, 2'd1); step();
    chk("lhu_in1", wb_in1, 32'h0000_BEEF);
    drive(1, 32'h2002, 32'hBEEF_0000, 5'd7, 1, 1, 3'b010, 2'd1); step();
    chk("lw_mis", {31'b0, wb_load_misaligned}, 32'd1);
    chk("lw_in1", wb_in1, 32'd0);
    chk("lw_rw", {31'b0, wb_reg_write}, 32'd0);
    drive(1, 32'h2002, 32'hBEEF_0000, 5'd7, 1, 0, 3'b010, 2'd1); step();
    chk("noread_mis", {31'b0, wb_load_misaligned}, 32'd0);
    chk("noread_in1", wb_in1, 32'hBEEF_0000);

    // x0 destination: valid but no write, still retires
    drive(1, 32'h55, 32'h0, 5'd0, 1, 0, 3'b000, 2'd0); step();
    chk("x0_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("x0_valid", {31'b0, wb_valid}, 32'd1);
    cnt0 = m.cnt;
    drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 3'b000, 2'd0); step();
    chk("x0_retire", retired_count, cnt0 + 32'd1);

    // stall for three cycles with changing inputs
    drive(1, 32'hA5A5_0004, 32'h1234_5678, 5'd9, 1, 1, 3'b010, 2'd0); step();
    last = m;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_in(); step(); end
    chk("stall_in0", wb_in0, last.in0);
    chk("stall_in1", wb_in1, 32'h1234_5678);
    // stall with flush: bubble, data held
    flush = 1'b1; rand_in(); step();
    chk("sf_valid", {31'b0, wb_valid}, 32'd0);
    chk("sf_in0", wb_in0, last.in0);
    chk("sf_in2", wb_in2, last.in2);
    stall = 1'b0; flush = 1'b0;

    // randomized traffic with occasional stall and flush
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rand_in();
      step();
    end
    stall = 1'b0; flush = 1'b0;

    // counter wrap
    drive(1, 32'h10, 32'h0, 5'd3, 1, 0, 3'b000, 2'd0); step();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m.cnt = 32'hFFFF_FFFF;
    drive(1, 32'h14, 32'h0, 5'd3, 1, 0, 3'b000, 2'd0); step();
    chk("wrap", retired_count, 32'd0);

    // reset during a stall with a valid instruction held
    drive(1, 32'h20, 32'h0, 5'd4, 1, 0, 3'b000, 2'd2); step();
    stall = 1'b1; rst_n = 1'b0; rand_in(); step();
    chk("rs_valid", {31'b0, wb_valid}, 32'd0);
    chk("rs_in0", wb_in0, 32'd0);
    chk("rs_cnt", retired_count, 32'd0);
    stall = 1'b0; rst_n = 1'b1;
    drive(1, 32'h0000_0301, 32'hCAFE_F00D, 5'd8, 1, 1, 3'b100, 2'd1); step();
    chk("post_rst_in1", wb_in1, 32'h0000_00F0);
    chk("post_rst_valid", {31'b0, wb_valid}, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
